fft_output_rescaler: RTL and testbench
======================================

Name: fft_output_rescaler

Overview:
Streaming post-processor at the FFT output. Every butterfly add in the datapath halves its result (33-bit sum, top 32 bits kept), so the outputs are scaled down by 2^SHIFT. This block reverses that scaling on each complex output sample: arithmetic left shift by SHIFT, with saturation. It also tags sample index and end-of-frame, checks frame alignment, and sits between the last butterfly stage and the output consumer behind a valid/ready handshake.

Parameters:
DATA_W, 32, width of each signed real/imag component
SHIFT, 2, left-shift amount (number of halving stages to undo); legal 0..DATA_W-1
FRAME_LEN, 16, samples per FFT frame; power of two
IDX_W, 4, index width = log2(FRAME_LEN)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept input sample
s_re  in  DATA_W  signed real part, scaled by 2^-SHIFT
s_im  in  DATA_W  signed imag part, scaled by 2^-SHIFT
s_last  in  1  producer marks final sample of frame
m_valid  out  1  output sample valid
m_ready  in  1  consumer accepts output
m_re  out  DATA_W  rescaled signed real part
m_im  out  DATA_W  rescaled signed imag part
m_index  out  IDX_W  sample index within frame, 0..FRAME_LEN-1
m_last  out  1  high with m_valid when m_index == FRAME_LEN-1
sat_flag  out  1  sticky: some component saturated since last clear
frame_err  out  1  one-cycle pulse on s_last misalignment
clr  in  1  synchronous clear of sat_flag

Behaviour:
- Reset (rst_n low, async): m_valid=0, m_re=0, m_im=0, m_index=0, m_last=0, sat_flag=0, frame_err=0, internal index counter=0, FSM=EMPTY. s_ready=1 combinationally after reset.
- FSM (single output register): EMPTY (no held sample) and FULL (sample held, m_valid=1).
  - EMPTY: s_valid -> capture, go FULL.
  - FULL: m_ready & s_valid -> replace with new sample, stay FULL. m_ready & !s_valid -> EMPTY. !m_ready -> hold all m_* stable.
- s_ready = !m_valid | m_ready (combinational). Input transfer = s_valid & s_ready. Output transfer = m_valid & m_ready.
- Latency: 1 cycle; sustained throughput 1 sample/cycle with m_ready held high.
- Arithmetic, per component independently: form x <<< SHIFT in DATA_W+SHIFT bits.
  - Result above 2^(DATA_W-1)-1 -> 0x7FFF_FFFF.
  - Result below -2^(DATA_W-1) -> 0x8000_0000.
  - Otherwise -> low DATA_W bits.
  - SHIFT=0 is a pass-through.
- sat_flag: set on any input transfer whose re or im saturated. clr clears it; clr and a new saturation in the same cycle -> flag stays 1.
- Index: counter is captured into m_index on each input transfer, then increments, wrapping FRAME_LEN-1 -> 0. m_last is registered with the sample (index == FRAME_LEN-1).
- Frame check, evaluated on each input transfer:
  - s_last=1 at index != FRAME_LEN-1 -> frame_err pulses next cycle; counter resyncs to 0 for the next sample.
  - s_last=0 at index == FRAME_LEN-1 -> frame_err pulses; counter wraps normally.
  - The sample itself is still passed through with its original index.
- Backpressure: no input is lost or duplicated. The counter advances only on input transfer.
- A mid-frame reset discards the held sample and restarts at index 0. The block does not resync to the producer beyond the s_last rule.

Decomposition:
- Shared FFT package holds DATA_W, FRAME_LEN, IDX_W, SHIFT default, and the saturation limit constants MAX_POS and MAX_NEG.
- One sub-module, sat_shl: combinational DATA_W-bit saturating left shift with a sat output. Instantiated twice (re, im); reusable by other scaling stages.

Test Plan:
- Basic: s_re=0x1000_0000, s_im=0xF000_0000, SHIFT=2, m_ready=1 -> next cycle m_re=0x4000_0000, m_im=0xC000_0000, m_index=0, sat_flag=0.
- Saturation: s_re=0x2000_0000 -> m_re=0x7FFF_FFFF. s_im=0xDFFF_FFFF -> m_im=0x8000_0000. s_re=0xE000_0000 -> exactly 0x8000_0000 with no saturation on that component. sat_flag=1 until clr pulse, then 0.
- Full frame: 16 back-to-back samples with s_last on the 16th -> m_index 0..15, m_last only on index 15, no frame_err, next frame starts at index 0.
- Backpressure: m_ready low for 3 cycles mid-frame while s_valid high -> s_ready=0, m_* stable; on release no gap or duplication, and indices stay contiguous.
- Misalignment: s_last on sample index 5 -> frame_err pulse one cycle later; the following sample has m_index=0. Missing s_last on index 15 -> frame_err pulse.
- Async reset: assert rst_n low mid-frame with m_valid=1 -> m_valid=0 immediately (no clock edge needed); after release the first sample has m_index=0.

Source files
------------

// File: rtl/fft_output_rescaler_pkg.sv
// Shared FFT output-stage definitions.
//   FFT_DATA_W    : signed component width
//   FFT_FRAME_LEN : samples per frame (power of two)
//   FFT_IDX_W     : log2(FFT_FRAME_LEN)
//   FFT_SHIFT     : default number of halving stages to undo
//   MAX_POS/NEG   : saturation limits for FFT_DATA_W-bit signed values
//   fsm_e         : output register occupancy state
package fft_output_rescaler_pkg;

  localparam int FFT_DATA_W    = 32;
  localparam int FFT_FRAME_LEN = 16;
  localparam int FFT_IDX_W     = 4;
  localparam int FFT_SHIFT     = 2;

  localparam logic [FFT_DATA_W-1:0] MAX_POS = {1'b0, {(FFT_DATA_W-1){1'b1}}};
  localparam logic [FFT_DATA_W-1:0] MAX_NEG = {1'b1, {(FFT_DATA_W-1){1'b0}}};

  // Two components per complex sample, handled as parallel lanes.
  localparam int NUM_LANES = 2;
  localparam int LANE_RE   = 0;
  localparam int LANE_IM   = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fsm_e;

endpackage

// File: rtl/fft_output_rescaler_sat_shl.sv
// sat_shl: combinational saturating arithmetic left shift.
//   din  : W-bit signed input
//   dout : din <<< SH, clamped to the W-bit signed range
//   sat  : high when clamping occurred
// SH = 0 degenerates to a pass-through (the overflow window is one bit).
module sat_shl #(
  parameter int W  = 32,
  parameter int SH = 2
) (
  input  logic signed [W-1:0] din,
  output logic        [W-1:0] dout,
  output logic                sat
);

  localparam logic [W-1:0] LIM_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] LIM_NEG = {1'b1, {(W-1){1'b0}}};

  logic signed [W+SH-1:0] ext;
  logic signed [W+SH-1:0] shl;
  logic        [SH:0]     hi;

  assign ext = (W+SH)'(din);   // sign-extending cast
  assign shl = ext <<< SH;
  // Result fits in W bits iff everything from the new sign bit upward agrees.
  assign hi  = shl[W+SH-1:W-1];
  assign sat = !((&hi) || !(|hi));

  always_comb begin
    dout = shl[W-1:0];
    if (sat) dout = din[W-1] ? LIM_NEG : LIM_POS;
  end

endmodule

// File: rtl/fft_output_rescaler.sv
// fft_output_rescaler: undoes the 2^-SHIFT butterfly scaling on each complex
// FFT output sample (saturating), tags index / end-of-frame and checks frame
// alignment. Single output register behind valid/ready on both sides.
//   clk, rst_n            : clock, async active-low reset
//   s_valid/s_ready       : input handshake
//   s_re, s_im, s_last    : input sample and producer end-of-frame mark
//   m_valid/m_ready       : output handshake
//   m_re, m_im            : rescaled sample
//   m_index, m_last       : position in frame, last-sample tag
//   sat_flag, clr         : sticky saturation flag and its sync clear
//   frame_err             : one-cycle pulse on s_last misalignment
module fft_output_rescaler
  import fft_output_rescaler_pkg::*;
#(
  parameter int DATA_W    = FFT_DATA_W,
  parameter int SHIFT     = FFT_SHIFT,
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int IDX_W     = FFT_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_re,
  input  logic [DATA_W-1:0] s_im,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_re,
  output logic [DATA_W-1:0] m_im,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  output logic              sat_flag,
  output logic              frame_err,
  input  logic              clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN-1);

  fsm_e st, st_nxt;

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_in, lane_out;
  logic [NUM_LANES-1:0]             lane_sat;
  logic [IDX_W-1:0]                 cnt;
  logic                             in_xfer;
  logic                             at_last;

  // Per-component rescale lanes
  assign lane_in[LANE_RE] = s_re;
  assign lane_in[LANE_IM] = s_im;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sat_shl #(.W(DATA_W), .SH(SHIFT)) u_shl (
      .din  (lane_in[l]),
      .dout (lane_out[l]),
      .sat  (lane_sat[l])
    );
  end

  // Handshake
  assign m_valid = (st == ST_FULL);
  assign s_ready = !m_valid || m_ready;
  assign in_xfer = s_valid && s_ready;
  assign at_last = (cnt == LAST_IDX);

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_EMPTY;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_EMPTY: if (s_valid)             st_nxt = ST_FULL;
      ST_FULL:  if (m_ready && !s_valid) st_nxt = ST_EMPTY;
      default:                           st_nxt = ST_EMPTY;
    endcase
  end

  // Output register: loads only on input transfer, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_re    <= '0;
      m_im    <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
    end else if (in_xfer) begin
      m_re    <= lane_out[LANE_RE];
      m_im    <= lane_out[LANE_IM];
      m_index <= cnt;
      m_last  <= at_last;
    end
  end

  // Index counter and frame check. An early s_last resyncs to 0; a missing
  // s_last only flags, the counter wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= in_xfer && (s_last != at_last);
      if (in_xfer) begin
        if (s_last && !at_last) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
      end
    end
  end

  // Sticky saturation; a new saturation wins over clr in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag <= 1'b0;
    else        sat_flag <= (sat_flag && !clr) || (in_xfer && (|lane_sat));
  end

endmodule

// File: tb/tb_fft_output_rescaler.sv
// Directed self-checking bench for fft_output_rescaler (default parameters).
module tb_fft_output_rescaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_re, s_im;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_re, m_im;
  logic [3:0]  m_index;
  logic        sat_flag, frame_err, clr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_output_rescaler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_re      (s_re),
    .s_im      (s_im),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_re      (m_re),
    .m_im      (m_im),
    .m_index   (m_index),
    .m_last    (m_last),
    .sat_flag  (sat_flag),
    .frame_err (frame_err),
    .clr       (clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
    s_valid = 1'b1; s_re = re; s_im = im; s_last = last;
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    s_valid = 1'b0; s_last = 1'b0; clr = 1'b0; m_ready = 1'b1;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_re = '0; s_im = '0;
    m_ready = 1'b1; clr = 1'b0;
    #3;
    // Reset state
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_index", m_index, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ferr", frame_err, 0);
    #4 rst_n = 1'b1;

    // Basic rescale
    send(32'h1000_0000, 32'hF000_0000, 1'b0);
    chk("basic_valid", m_valid, 1);
    chk("basic_re", m_re, 32'h4000_0000);
    chk("basic_im", m_im, 32'hC000_0000);
    chk("basic_idx", m_index, 0);
    chk("basic_sat", sat_flag, 0);
    step();
    chk("basic_drain", m_valid, 0);

    // Saturation
    do_reset();
    send(32'h2000_0000, 32'hDFFF_FFFF, 1'b0);
    chk("sat_re_pos", m_re, 32'h7FFF_FFFF);
    chk("sat_im_neg", m_im, 32'h8000_0000);
    chk("sat_flag_set", sat_flag, 1);
    send(32'hE000_0000, 32'h0000_0000, 1'b0);
    chk("sat_exact_min", m_re, 32'h8000_0000);
    chk("sat_sticky", sat_flag, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("sat_clr", sat_flag, 0);
    send(32'hE000_0000, 32'h1FFF_FFFF, 1'b0);
    chk("sat_edge_noflag", sat_flag, 0);
    chk("sat_edge_im", m_im, 32'h7FFF_FFFC);
    clr = 1'b1;
    send(32'h7000_0000, 32'h0, 1'b0);
    clr = 1'b0;
    chk("sat_clr_vs_set", sat_flag, 1);

    // Full frame, then next frame starts at 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(32'(i), -32'(i), i == 15);
      chk("frm_idx", m_index, 32'(i));
      chk("frm_last", m_last, (i == 15) ? 1 : 0);
      chk("frm_ferr", frame_err, 0);
      chk("frm_re", m_re, 32'(i * 4));
    end
    send(32'h0000_0005, 32'h0, 1'b0);
    chk("frm_next_idx", m_index, 0);
    chk("frm_next_re", m_re, 32'h14);

    // Backpressure
    do_reset();
    send(32'h0000_0010, 32'h0, 1'b0);
    send(32'h0000_0011, 32'h0, 1'b0);
    chk("bp_pre_idx", m_index, 1);
    m_ready = 1'b0;
    s_valid = 1'b1; s_re = 32'h0000_0012; s_im = 32'h0; s_last = 1'b0;
    #1;
    chk("bp_s_ready", s_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_idx", m_index, 1);
      chk("bp_hold_re", m_re, 32'h44);
      chk("bp_hold_srdy", s_ready, 0);
    end
    m_ready = 1'b1;
    step();
    chk("bp_rel_idx", m_index, 2);
    chk("bp_rel_re", m_re, 32'h48);
    send(32'h0000_0013, 32'h0, 1'b0);
    chk("bp_next_idx", m_index, 3);
    chk("bp_next_re", m_re, 32'h4C);

    // Misalignment: early s_last, then missing s_last
    do_reset();
    for (int i = 0; i < 6; i++) send(32'(i), 32'h0, i == 5);
    chk("mis_early_idx", m_index, 5);
    chk("mis_early_ferr", frame_err, 1);
    send(32'h0000_0001, 32'h0, 1'b0);
    chk("mis_resync_idx", m_index, 0);
    chk("mis_ferr_pulse", frame_err, 0);
    for (int i = 1; i < 16; i++) send(32'(i), 32'h0, 1'b0);
    chk("mis_miss_idx", m_index, 15);
    chk("mis_miss_last", m_last, 1);
    chk("mis_miss_ferr", frame_err, 1);
    send(32'h0, 32'h0, 1'b0);
    chk("mis_wrap_idx", m_index, 0);

    // Async reset with a held sample
    send(32'h0000_0001, 32'h0, 1'b0);
    chk("ar_pre_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", m_valid, 0);
    chk("ar_idx", m_index, 0);
    #2 rst_n = 1'b1;
    send(32'h0000_0002, 32'h0, 1'b0);
    chk("ar_first_idx", m_index, 0);
    chk("ar_first_re", m_re, 32'h8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
